// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer datapath: element widths,
// lane slicing helpers, group state and the ReLU/requantization function.
package nn_pkg;

   localparam int LANES    = 8;
   localparam int WORDSIZE = 8;
   localparam int ACCW     = 24;

   typedef enum logic {IDLE, ACCUM} state_t;

   function automatic int lane_base(input int n);
      return 64 * n;
   endfunction

   function automatic int elem_base(input int j);
      return WORDSIZE * j;
   endfunction

   // Negative sums clamp to zero; positive sums are shifted down and saturate at 127.
   function automatic logic [7:0] relu_requant(input logic signed [ACCW-1:0] s, input int shift);
      logic signed [ACCW-1:0] t;
      t = s >>> shift;
      if (s < 0)
         return 8'd0;
      else if (t > 127)
         return 8'd127;
      else
         return t[7:0];
   endfunction

endpackage

// File: rtl/layer_mac_relu_dot8.sv
// Combinational signed dot product of eight 8-bit activations with eight 8-bit weights.
module dot8
   import nn_pkg::*;
(
   input  logic        [63:0] a,
   input  logic        [63:0] w,
   output logic signed [18:0] dot
);

   logic signed [15:0] prod;

   always_comb begin
      dot  = '0;
      prod = '0;
      for (int j = 0; j < 8; j++) begin
         prod = $signed(a[elem_base(j) +: 8]) * $signed(w[elem_base(j) +: 8]);
         dot  = dot + 19'(prod);
      end
   end

endmodule

// File: rtl/layer_mac_relu.sv
// Eight-lane MAC over a neuron group, followed by bias add, ReLU and requantization,
// with a one-entry output buffer.
module layer_mac_relu
   import nn_pkg::*;
#(
   parameter int SHIFT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_first,
   input  logic         in_last,
   input  logic [63:0]  act,
   input  logic [511:0] weight,
   input  logic [63:0]  bias,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [63:0]  out_data,
   output logic         err
);

   state_t                 state, state_nxt;
   logic signed [ACCW-1:0] acc     [LANES];
   logic signed [ACCW-1:0] acc_nxt [LANES];
   logic signed [ACCW-1:0] sum     [LANES];
   logic signed [18:0]     dot     [LANES];
   logic [63:0]            result;
   logic                   accept, finish, err_nxt;

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      dot8 u_dot (
         .a   (act),
         .w   (weight[lane_base(n) +: 64]),
         .dot (dot[n])
      );
   end

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A same-beat in_first restarts the sum from zero rather than from acc.
   always_comb begin
      result = '0;
      for (int n = 0; n < LANES; n++) begin
         sum[n] = (in_first ? '0 : acc[n]) + ACCW'(dot[n])
                  + (ACCW'($signed(bias[elem_base(n) +: 8])) <<< SHIFT);
         result[elem_base(n) +: 8] = relu_requant(sum[n], SHIFT);
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err;
      finish    = 1'b0;
      acc_nxt   = acc;
      if (accept) begin
         if (in_first) begin
            if (state == ACCUM) err_nxt = 1'b1;
            for (int n = 0; n < LANES; n++) acc_nxt[n] = ACCW'(dot[n]);
            state_nxt = ACCUM;
         end else if (state == ACCUM) begin
            for (int n = 0; n < LANES; n++) acc_nxt[n] = acc[n] + ACCW'(dot[n]);
         end else begin
            err_nxt = 1'b1;
         end
         if (in_last && (in_first || state == ACCUM)) begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         err   <= 1'b0;
         for (int n = 0; n < LANES; n++) acc[n] <= '0;
      end else begin
         state <= state_nxt;
         err   <= err_nxt;
         acc   <= acc_nxt;
      end
   end

   // A newly finished group takes priority over draining, keeping full throughput.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (finish) begin
         out_valid <= 1'b1;
         out_data  <= result;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_layer_mac_relu.sv
// Directed-vector bench for layer_mac_relu; one instance per requantization shift.
module tb_layer_mac_relu;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_first, in_last, out_ready;
   logic [63:0]  act, bias;
   logic [511:0] weight;
   logic         in_ready0, out_valid0, err0;
   logic [63:0]  out_data0;
   logic         in_ready4, out_valid4, err4;
   logic [63:0]  out_data4;
   int           vectors = 0;
   int           miscompares = 0;

   always #5 clk = ~clk;

   layer_mac_relu #(.SHIFT(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_first(in_first), .in_last(in_last), .act(act), .weight(weight), .bias(bias),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .err(err0)
   );

   layer_mac_relu #(.SHIFT(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_first(in_first), .in_last(in_last), .act(act), .weight(weight), .bias(bias),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .err(err4)
   );

   task automatic beat(input logic f, input logic l, input logic [63:0] a,
                       input logic [511:0] w, input logic [63:0] b);
      in_valid = 1'b1; in_first = f; in_last = l; act = a; weight = w; bias = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      vectors++;
      if (out_valid0 !== 1'b0 || out_data0 !== 64'd0 || err0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: valid=%b data=%h err=%b, want 0/0/0", out_valid0, out_data0, err0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (in_ready0 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ready: in_ready=%b, want 1", in_ready0);
      end
   endtask

   task automatic test_single();
      beat(1'b1, 1'b1, {8{8'd1}}, {64{8'd1}}, 64'd0);
      vectors++;
      if (out_valid0 !== 1'b1 || out_data0 !== {8{8'd8}}) begin
         miscompares++;
         $display("[TB] FAIL single_beat: valid=%b data=%h, want 1 %h", out_valid0, out_data0, {8{8'd8}});
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_drain: valid=%b, want 0", out_valid0);
      end
   endtask

   task automatic test_group4();
      for (int i = 0; i < 4; i++) begin
         beat(i == 0, i == 3, {8{8'd2}}, {64{8'd3}},
              (i == 3) ? 64'h0706050403020100 : 64'hFFFF_FFFF_FFFF_FFFF);
         if (i < 3) begin
            vectors++;
            if (out_valid4 !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL group4_early_valid beat %0d: valid=%b, want 0", i, out_valid4);
            end
         end
      end
      vectors++;
      if (out_valid4 !== 1'b1 || out_data4 !== 64'h131211100F0E0D0C) begin
         miscompares++;
         $display("[TB] FAIL group4_result: valid=%b data=%h, want 1 131211100f0e0d0c", out_valid4, out_data4);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      beat(1'b1, 1'b1, {8{8'd127}}, {384'd0, {8{8'h7F}}, {8{8'h80}}}, 64'h0000_0000_0000_7F00);
      vectors++;
      if (out_data0 !== 64'h0000_0000_0000_7F00) begin
         miscompares++;
         $display("[TB] FAIL saturate_shift0: data=%h, want 0000000000007f00", out_data0);
      end
      vectors++;
      if (out_data4 !== 64'h0000_0000_0000_7F00) begin
         miscompares++;
         $display("[TB] FAIL saturate_shift4: data=%h, want 0000000000007f00", out_data4);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      beat(1'b1, 1'b1, {8{8'd1}}, {64{8'd1}}, 64'd0);
      // Illegal pattern held while stalled must not raise err.
      in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1;
      act = {8{8'd2}}; weight = {64{8'd1}}; bias = 64'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out_data0 !== {8{8'd8}} || err0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall cycle %0d: ready=%b valid=%b data=%h err=%b, want 0 1 %h 0",
                     i, in_ready0, out_valid0, out_data0, err0, {8{8'd8}});
         end
      end
      in_first = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      vectors++;
      if (out_valid0 !== 1'b1 || out_data0 !== {8{8'h10}}) begin
         miscompares++;
         $display("[TB] FAIL release_same_edge: valid=%b data=%h, want 1 %h", out_valid0, out_data0, {8{8'h10}});
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid0 !== 1'b0 || err0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL release_drain: valid=%b err=%b, want 0 0", out_valid0, err0);
      end
   endtask

   task automatic test_idle_orphan();
      beat(1'b0, 1'b1, {8{8'd1}}, {64{8'd1}}, 64'd0);
      vectors++;
      if (out_valid0 !== 1'b0 || err0 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL idle_orphan: valid=%b err=%b, want 0 1", out_valid0, err0);
      end
   endtask

   task automatic test_restart();
      do_reset();
      beat(1'b1, 1'b0, {8{8'd1}}, {64{8'd1}}, 64'd0);
      beat(1'b0, 1'b0, {8{8'd1}}, {64{8'd1}}, 64'd0);
      vectors++;
      if (err0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL restart_pre_err: err=%b, want 0", err0);
      end
      beat(1'b1, 1'b0, {8{8'd2}}, {64{8'd1}}, 64'd0);
      beat(1'b0, 1'b1, {8{8'd1}}, {64{8'd1}}, 64'd0);
      vectors++;
      if (out_valid0 !== 1'b1 || out_data0 !== {8{8'd24}} || err0 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL restart_result: valid=%b data=%h err=%b, want 1 %h 1",
                  out_valid0, out_data0, err0, {8{8'd24}});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midgroup();
      beat(1'b1, 1'b0, {8{8'd1}}, {64{8'd1}}, 64'd0);
      beat(1'b0, 1'b0, {8{8'd1}}, {64{8'd1}}, 64'd0);
      do_reset();
      vectors++;
      if (out_valid0 !== 1'b0 || err0 !== 1'b0 || out_data0 !== 64'd0) begin
         miscompares++;
         $display("[TB] FAIL midgroup_reset: valid=%b err=%b data=%h, want 0 0 0", out_valid0, err0, out_data0);
      end
      beat(1'b1, 1'b1, {8{8'd1}}, {64{8'd1}}, 64'd0);
      vectors++;
      if (out_valid0 !== 1'b1 || out_data0 !== {8{8'd8}} || err0 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL post_reset_group: valid=%b data=%h err=%b, want 1 %h 0",
                  out_valid0, out_data0, err0, {8{8'd8}});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      act = '0; weight = '0; bias = '0;
      test_reset();
      test_single();
      test_group4();
      test_saturate();
      test_backpressure();
      test_idle_orphan();
      test_restart();
      test_reset_midgroup();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
